// File: rtl/dadda_mac_if.sv
// Bus bundle for dadda_mac: operand handshake, external multiplier
// operands/product, and result handshake.
interface dadda_mac_if #(
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_a;
   logic [3:0]       in_b;
   logic             in_last;
   logic [3:0]       mul_a;
   logic [3:0]       mul_b;
   logic [7:0]       mul_op;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_last, mul_op, out_ready,
      output in_ready, mul_a, mul_b, out_valid, out_acc, out_count, out_ovf
   );

   modport master (
      output in_valid, in_a, in_b, in_last, mul_op, out_ready,
      input  in_ready, mul_a, mul_b, out_valid, out_acc, out_count, out_ovf
   );
endinterface

// File: rtl/dadda_mac.sv
// dadda_mac: dot-product accumulator around an external 4x4 dadda multiplier.
// Operands are registered onto mul_a/mul_b, the product comes back on mul_op
// and is added one cycle later. Build option DADDA_MAC_SATURATE_EN clamps the
// accumulator at all-ones instead of wrapping.
module dadda_mac #(
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input logic        clk,
   input logic        rst,
   dadda_mac_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [3:0]       mul_a_q, mul_a_d;
   logic [3:0]       mul_b_q, mul_b_d;
   logic             p_vld_q, p_vld_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             accept;
   logic             drain;
   logic [ACC_W:0]   sum;

   assign bus.in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.out_acc   = acc_q;
   assign bus.out_count = cnt_q;
   assign bus.out_ovf   = ovf_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign drain  = (state_q == S_DONE) && bus.out_ready;
   // one extra bit catches the carry out of the accumulator MSB
   assign sum    = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, bus.mul_op};

   // FSM: FLUSH is the one cycle that lets the last product land before DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_ACCUM: if (accept) state_d = bus.in_last ? S_FLUSH : S_ACCUM;
         S_FLUSH:         state_d = S_DONE;
         S_DONE:          if (drain) state_d = S_IDLE;
         default:         state_d = S_IDLE;
      endcase
   end

   // datapath: load operands on accept, add the previous cycle's product
   always_comb begin
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      p_vld_d = accept;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (accept) begin
         mul_a_d = bus.in_a;
         mul_b_d = bus.in_b;
         cnt_d   = cnt_q + CNT_W'(1);
      end
      if (p_vld_q) begin
`ifdef DADDA_MAC_SATURATE_EN
         if (sum[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
`else
         acc_d = sum[ACC_W-1:0];
         ovf_d = ovf_q | sum[ACC_W];
`endif
      end
      // result consumed: start the next dot product from zero
      if (drain) begin
         acc_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end
   end

   // state registers; reset drops any partial sum and in-flight product
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mul_a_q <= '0;
         mul_b_q <= '0;
         p_vld_q <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         p_vld_q <= p_vld_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_dadda_mac.sv
// Bench for dadda_mac: a 16-bit and a 9-bit accumulator share one stimulus
// stream; each is compared against an arithmetic model of the dot product.
module tb_dadda_mac;
`ifdef DADDA_MAC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      string name;
      int    a, b, n, gap;
      int    e16, ecnt, eo16, e9, eo9;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid, in_last, out_ready;
   logic [3:0] in_a, in_b;
   int         checks = 0;
   int         errors = 0;
   int         qa[$];
   int         qb[$];

   dadda_mac_if #(.ACC_W(16), .CNT_W(8)) if16 ();
   dadda_mac_if #(.ACC_W(9),  .CNT_W(8)) if9 ();

   assign if16.in_valid  = in_valid;
   assign if16.in_a      = in_a;
   assign if16.in_b      = in_b;
   assign if16.in_last   = in_last;
   assign if16.out_ready = out_ready;
   assign if16.mul_op    = {4'b0, if16.mul_a} * {4'b0, if16.mul_b};
   assign if9.in_valid   = in_valid;
   assign if9.in_a       = in_a;
   assign if9.in_b       = in_b;
   assign if9.in_last    = in_last;
   assign if9.out_ready  = out_ready;
   assign if9.mul_op     = {4'b0, if9.mul_a} * {4'b0, if9.mul_b};

   dadda_mac #(.ACC_W(16), .CNT_W(8)) u16 (.clk(clk), .rst(rst), .bus(if16));
   dadda_mac #(.ACC_W(9),  .CNT_W(8)) u9  (.clk(clk), .rst(rst), .bus(if9));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // reference: exact dot product, then reduced to the accumulator width
   function automatic longint dot();
      longint t = 0;
      for (int i = 0; i < qa.size(); i++) t += longint'(qa[i]) * longint'(qb[i]);
      return t;
   endfunction

   function automatic longint exp_acc(input longint total, input int w);
      longint lim = longint'(1) << w;
      if (SAT) return (total >= lim) ? lim - 1 : total;
      return total % lim;
   endfunction

   function automatic longint exp_ovf(input longint total, input int w);
      return (total >= (longint'(1) << w)) ? 1 : 0;
   endfunction

   task automatic send_terms(input int gap, input bit rgap, input bit with_last);
      int g;
      int b;
      for (int i = 0; i < qa.size(); i++) begin
         in_valid = 1'b1;
         in_a     = 4'(qa[i]);
         in_b     = 4'(qb[i]);
         in_last  = with_last && (i == qa.size() - 1);
         b = 0;
         while (!if16.in_ready && b < 50) begin
            tick();
            b++;
         end
         if (b == 50) chk("in_ready_timeout", 0, 1);
         tick();
         in_valid = 1'b0;
         in_last  = 1'b0;
         g = rgap ? $urandom_range(gap, 0) : gap;
         if (i != qa.size() - 1) repeat (g) tick();
         chk("mul_a_hold", if16.mul_a, qa[i]);
         chk("mul_b_hold", if16.mul_b, qb[i]);
      end
   endtask

   task automatic check_result(input string name, input longint e16, input longint ecnt,
                               input longint eo16, input longint e9, input longint eo9);
      chk({name, "_acc16"}, if16.out_acc, e16);
      chk({name, "_cnt16"}, if16.out_count, ecnt);
      chk({name, "_ovf16"}, if16.out_ovf, eo16);
      chk({name, "_acc9"},  if9.out_acc, e9);
      chk({name, "_cnt9"},  if9.out_count, ecnt);
      chk({name, "_ovf9"},  if9.out_ovf, eo9);
   endtask

   // full transaction with out_ready high: FLUSH cycle, DONE cycle, back to IDLE
   task automatic do_txn(input string name, input int gap, input bit rgap, input longint e16,
                         input longint ecnt, input longint eo16, input longint e9, input longint eo9);
      send_terms(gap, rgap, 1'b1);
      chk({name, "_flush_vld"}, if16.out_valid, 0);
      chk({name, "_flush_rdy"}, if16.in_ready, 0);
      tick();
      chk({name, "_done_vld"}, if16.out_valid, 1);
      chk({name, "_done_vld9"}, if9.out_valid, 1);
      check_result(name, e16, ecnt, eo16, e9, eo9);
      tick();
      chk({name, "_idle_vld"}, if16.out_valid, 0);
      chk({name, "_idle_rdy"}, if16.in_ready, 1);
      chk({name, "_idle_acc"}, if16.out_acc, 0);
      chk({name, "_idle_cnt"}, if9.out_count, 0);
   endtask

   initial begin
      vec_t   tbl[6];
      longint t;
      int     n;
      tbl[0] = '{"single",   6,  6, 1, 0,  36, 1, 0,  36, 0};
      tbl[1] = '{"four_gap", 15, 15, 4, 1, 900, 4, 0, SAT ? 511 : 388, 1};
      tbl[2] = '{"three",    15, 15, 3, 0, 675, 3, 0, SAT ? 511 : 163, 1};
      tbl[3] = '{"zero_a",   0,  9, 2, 0,   0, 2, 0,   0, 0};
      tbl[4] = '{"two_gap2", 15, 15, 2, 2, 450, 2, 0, 450, 0};
      tbl[5] = '{"ones",     1,  1, 1, 0,   1, 1, 0,   1, 0};

      in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;

      // reset values, sampled with no clock edge yet
      #2;
      chk("rst_in_ready", if16.in_ready, 1);
      chk("rst_out_valid", if16.out_valid, 0);
      chk("rst_acc", if16.out_acc, 0);
      chk("rst_mul_a", if16.mul_a, 0);
      tick();
      tick();
      rst = 1'b0;
      chk("post_rst_in_ready", if16.in_ready, 1);

      for (int v = 0; v < 6; v++) begin
         qa.delete(); qb.delete();
         for (int k = 0; k < tbl[v].n; k++) begin qa.push_back(tbl[v].a); qb.push_back(tbl[v].b); end
         do_txn(tbl[v].name, tbl[v].gap, 1'b0, tbl[v].e16, tbl[v].ecnt, tbl[v].eo16, tbl[v].e9, tbl[v].eo9);
      end

      // backpressure: result held for 5 cycles, then drained
      out_ready = 1'b0;
      qa = '{4}; qb = '{5};
      send_terms(0, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_vld", if16.out_valid, 1);
         chk("bp_acc", if16.out_acc, 20);
         chk("bp_rdy", if16.in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_rel_rdy", if16.in_ready, 1);
      chk("bp_rel_acc", if16.out_acc, 0);
      chk("bp_rel_vld", if16.out_valid, 0);

      // reset mid-dot-product with a product still in flight
      qa = '{7, 9}; qb = '{3, 11};
      send_terms(0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_acc", if16.out_acc, 0);
      chk("mid_rst_cnt", if16.out_count, 0);
      chk("mid_rst_ovf", if9.out_ovf, 0);
      chk("mid_rst_vld", if16.out_valid, 0);
      chk("mid_rst_mul", if16.mul_a, 0);
      chk("mid_rst_rdy", if16.in_ready, 1);
      tick();
      rst = 1'b0;
      qa = '{3}; qb = '{5};
      do_txn("after_rst", 0, 1'b0, 15, 1, 0, 15, 0);

      // term counter wraps at 256
      qa.delete(); qb.delete();
      for (int k = 0; k < 257; k++) begin qa.push_back(1); qb.push_back(1); end
      do_txn("cnt_wrap", 0, 1'b0, 257, 1, 0, 257, 0);

      // randomized dot products against the arithmetic model
      for (int r = 0; r < 25; r++) begin
         qa.delete(); qb.delete();
         n = $urandom_range(6, 1);
         for (int k = 0; k < n; k++) begin
            qa.push_back($urandom_range(15, 0));
            qb.push_back($urandom_range(15, 0));
         end
         t = dot();
         do_txn("rand", 2, 1'b1, exp_acc(t, 16), n % 256, exp_ovf(t, 16), exp_acc(t, 9), exp_ovf(t, 9));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dadda_mac.md
DADDA_MAC -- requirements
Module: dadda_mac

Interface
REQ-001 The module SHALL expose parameter ACC_W, default 16, accumulator width (legal range 9..32).
REQ-002 The module SHALL expose parameter CNT_W, default 8, term-counter width.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1, operand pair present.
REQ-006 The module SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-007 The module SHALL have ports in_a and in_b, input, 4 each, unsigned operands.
REQ-008 The module SHALL have port in_last, input, 1, marks the final pair of a dot product.
REQ-009 The module SHALL have ports mul_a and mul_b, output, 4 each, registered operands driving the 4x4 dadda multiplier's a/b.
REQ-010 The module SHALL have port mul_op, input, 8, the multiplier's combinational product of mul_a*mul_b.
REQ-011 The module SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-012 The module SHALL have ports out_acc (output, ACC_W), out_count (output, CNT_W) and out_ovf (output, 1): the sum, number of terms and the overflow flag.

Function
REQ-013 An operand pair SHALL be accepted on a rising edge with in_valid && in_ready; the pair loads into mul_a/mul_b and sets stage-1 valid p_vld.
REQ-014 When p_vld is 1, mul_op SHALL be zero-extended and added into the accumulator on the next edge; mul_a/mul_b SHALL hold their values when no pair is accepted.
REQ-015 The FSM SHALL have states IDLE, ACCUM, FLUSH and DONE.
REQ-016 IDLE->ACCUM on an accept with in_last=0; IDLE or ACCUM->FLUSH on an accept with in_last=1.
REQ-017 FLUSH->DONE unconditionally on the next edge, once the final product has been added.
REQ-018 DONE->IDLE on out_valid && out_ready; on that same edge the accumulator, count and ovf SHALL clear to 0.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM and 0 in FLUSH and DONE.
REQ-020 out_valid SHALL be 1 only in DONE; out_acc, out_count and out_ovf SHALL stay stable while out_valid && !out_ready.
REQ-021 Result latency SHALL be 2 cycles from acceptance of the in_last pair to out_valid=1.
REQ-022 out_count SHALL increment per accepted pair and wrap modulo 2^CNT_W.
REQ-023 Default arithmetic SHALL wrap the accumulator modulo 2^ACC_W, and out_ovf SHALL be set sticky on any carry out of bit ACC_W-1.
REQ-024 Gaps in in_valid between terms SHALL NOT alter the result.

Reset
REQ-025 While rst=1 the FSM SHALL be IDLE, and mul_a, mul_b, p_vld, the accumulator, out_count, out_ovf and out_valid SHALL be 0, independent of clk.
REQ-026 Reset asserted mid-transaction SHALL discard the partial sum and any pending product.
REQ-027 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-028 With macro DADDA_MAC_SATURATE_EN defined, an add that would exceed 2^ACC_W-1 SHALL clamp the accumulator to all-ones and set out_ovf; further adds SHALL keep it at all-ones.
REQ-029 Without DADDA_MAC_SATURATE_EN, REQ-023 wrap behaviour SHALL apply; handshake and latency SHALL be identical in both builds.

Verification
REQ-030 Single term: in_a=6, in_b=6, in_last=1, out_ready=1 -> out_valid=1 two cycles later, out_acc=36, out_count=1, out_ovf=0.
REQ-031 Four terms (15,15), in_last on the 4th, with 1-cycle in_valid gaps -> out_acc=900, out_count=4.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid held at 1, out_acc constant, in_ready=0; out_ready=1 for one cycle -> IDLE, in_ready=1, out_acc=0.
REQ-033 ACC_W=9, three terms (15,15) -> without the macro: out_acc=163, out_ovf=1; with DADDA_MAC_SATURATE_EN: out_acc=511, out_ovf=1.
REQ-034 rst pulse in ACCUM after 2 terms -> all outputs 0 asynchronously; the next transaction (3,5,in_last=1) -> out_acc=15, out_count=1.
